// File: rtl/uart_xmtr_fifo_if.sv
// Bus-side push handshake of the FIFO-fronted UART transmitter.
interface uart_xmtr_fifo_if #(
  parameter int WD_SIZE = 8
);
  logic [WD_SIZE-1:0] bus_data_i;
  logic               bus_vld_i;
  logic               bus_rdy_o;

  modport master (output bus_data_i, output bus_vld_i, input bus_rdy_o);
  modport slave  (input bus_data_i, input bus_vld_i, output bus_rdy_o);
endinterface

// File: rtl/uart_xmtr_fifo.sv
// Asynchronous serial transmitter fed by a TX FIFO; frames stream back-to-back.
//   state | meaning
//   IDLE  | line high, waiting for a queued word
//   START | start bit (line low)
//   DATA  | data bits, LSB first
//   PAR   | parity bit (only when PARITY != 0)
//   STOP  | stop bit(s); pops the next word on the very last cycle
module uart_xmtr_fifo #(
  parameter int WD_SIZE      = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_xmtr_fifo_if.slave               bus,
  output logic                          seri_data_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(WD_SIZE);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] DATA_LAST = BIW'(WD_SIZE - 1);
  localparam logic [BIW-1:0] STOP_LAST = BIW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic           ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [WD_SIZE-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BCW-1:0]       baud_q, baud_d;
  logic [BIW-1:0]       bit_q, bit_d;
  logic [WD_SIZE-1:0]   shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 seri_q, seri_d;
  logic                 rdy, push, pop, empty, bit_end;
  logic [WD_SIZE-1:0]   head;

  assign rdy           = (cnt_q != FULL_CNT);
  assign bus.bus_rdy_o = rdy;
  assign push          = bus.bus_vld_i && rdy;
  assign empty         = (cnt_q == '0);
  assign head          = mem_q[rd_ptr_q];
  assign bit_end       = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.bus_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      seri_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      seri_q  <= seri_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    seri_d  = 1'b1;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + BCW'(1);
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        seri_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        seri_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + BIW'(1);
          end
        end
      end
      PAR: begin
        seri_d = par_q;
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + BIW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Parity is latched from the whole word as it leaves the FIFO.
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ ODD_PAR;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign seri_data_o = seri_q;
  assign busy_o      = (state_q != IDLE);
  assign fifo_cnt_o  = cnt_q;
endmodule

// File: tb/tb_uart_xmtr_fifo.sv
// Bench for uart_xmtr_fifo: three configurations share one stimulus stream,
// each checked every cycle against a frame-timeline reference model.
module tb_uart_xmtr_fifo;
  localparam int NC   = 3;
  localparam int WD  [NC] = '{8, 8, 5};
  localparam int CPB [NC] = '{4, 4, 2};
  localparam int DEP [NC] = '{16, 4, 2};
  localparam int PAR [NC] = '{0, 1, 2};
  localparam int STP [NC] = '{1, 2, 1};
  localparam int MAXF = 4096;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       vld  = 1'b0;
  logic [8:0] data = '0;
  always #5 clk = ~clk;

  uart_xmtr_fifo_if #(.WD_SIZE(8)) bus0 ();
  uart_xmtr_fifo_if #(.WD_SIZE(8)) bus1 ();
  uart_xmtr_fifo_if #(.WD_SIZE(5)) bus2 ();
  assign bus0.bus_vld_i  = vld;
  assign bus1.bus_vld_i  = vld;
  assign bus2.bus_vld_i  = vld;
  assign bus0.bus_data_i = data[7:0];
  assign bus1.bus_data_i = data[7:0];
  assign bus2.bus_data_i = data[4:0];

  logic [NC-1:0] seri, busy;
  logic [4:0]    cnt0;
  logic [2:0]    cnt1;
  logic [1:0]    cnt2;

  uart_xmtr_fifo #(.WD_SIZE(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .seri_data_o(seri[0]), .busy_o(busy[0]), .fifo_cnt_o(cnt0));
  uart_xmtr_fifo #(.WD_SIZE(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .seri_data_o(seri[1]), .busy_o(busy[1]), .fifo_cnt_o(cnt1));
  uart_xmtr_fifo #(.WD_SIZE(5), .CLKS_PER_BIT(2), .FIFO_DEPTH(2), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .seri_data_o(seri[2]), .busy_o(busy[2]), .fifo_cnt_o(cnt2));

  // Model: each accepted word owns a line interval starting at st; nothing else.
  int         st [NC][MAXF];
  logic [8:0] fw [NC][MAXF];
  int         nf [NC];
  int         bs [NC];
  int         t;
  int         checks;
  int         errors;

  function automatic int flen(int k);
    return (1 + WD[k] + ((PAR[k] != 0) ? 1 : 0) + STP[k]) * CPB[k];
  endfunction

  function automatic int m_cnt(int k, int tt);
    int c = nf[k] - bs[k];
    for (int i = bs[k]; i < nf[k]; i++) if (st[k][i] - 1 <= tt) c--;
    return c;
  endfunction

  function automatic logic m_busy(int k, int tt);
    for (int i = bs[k]; i < nf[k]; i++)
      if (tt >= st[k][i] - 1 && tt < st[k][i] - 1 + flen(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic fbit(int k, logic [8:0] w, int j);
    if (j == 0) return 1'b0;
    if (j <= WD[k]) return w[j-1];
    if (PAR[k] != 0 && j == WD[k] + 1) return (^w) ^ (PAR[k] == 2);
    return 1'b1;
  endfunction

  function automatic logic m_line(int k, int tt);
    for (int i = bs[k]; i < nf[k]; i++)
      if (tt >= st[k][i] && tt < st[k][i] + flen(k))
        return fbit(k, fw[k][i], (tt - st[k][i]) / CPB[k]);
    return 1'b1;
  endfunction

  function automatic logic model_active();
    for (int k = 0; k < NC; k++) if (m_busy(k, t) || m_cnt(k, t) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int obs_cnt(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic logic obs_rdy(int k);
    case (k)
      0:       return bus0.bus_rdy_o;
      1:       return bus1.bus_rdy_o;
      default: return bus2.bus_rdy_o;
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0d observed=%0h expected=%0h", tag, k, t, o, e);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NC; k++) begin
      chk("line", k, 32'(seri[k]), 32'(m_line(k, t)));
      chk("busy", k, 32'(busy[k]), 32'(m_busy(k, t)));
      chk("cnt",  k, 32'(obs_cnt(k)), 32'(m_cnt(k, t)));
      chk("rdy",  k, 32'(obs_rdy(k)), 32'(m_cnt(k, t) < DEP[k]));
    end
  endtask

  task automatic step();
    bit pre [NC];
    int s;
    for (int k = 0; k < NC; k++) pre[k] = (m_cnt(k, t) < DEP[k]);
    @(posedge clk);
    t++;
    for (int k = 0; k < NC; k++) begin
      if (rst) bs[k] = nf[k];
      else if (vld && pre[k] && nf[k] < MAXF) begin
        s = t + 2;
        if (nf[k] > bs[k] && st[k][nf[k]-1] + flen(k) > s) s = st[k][nf[k]-1] + flen(k);
        st[k][nf[k]] = s;
        fw[k][nf[k]] = data & 9'((1 << WD[k]) - 1);
        nf[k]++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic push1(input logic [8:0] w);
    vld  = 1'b1;
    data = w;
    step();
    vld  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (g < 4000 && model_active()) begin
      step();
      g++;
    end
    chk("drain_bound", 0, 32'(g < 4000), 32'd1);
  endtask

  initial begin
    int         p;
    int         dens;
    logic [9:0] seq;
    checks = 0;
    errors = 0;
    t      = 0;
    for (int k = 0; k < NC; k++) begin
      nf[k] = 0;
      bs[k] = 0;
    end

    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < NC; k++) begin
      chk("rst_line", k, 32'(seri[k]), 32'd1);
      chk("rst_busy", k, 32'(busy[k]), 32'd0);
      chk("rst_cnt",  k, 32'(obs_cnt(k)), 32'd0);
      chk("rst_rdy",  k, 32'(obs_rdy(k)), 32'd1);
    end
    repeat (3) step();

    // Single word 0x4F: start bit two cycles after the push edge.
    push1(9'h04F);
    p = t;
    step();
    chk("lat_hi", 0, 32'(seri[0]), 32'd1);
    step();
    seq = 10'b10_0100_1111 << 1;
    seq[9] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk("frame4f", 0, 32'(seri[0]), 32'(seq[c/4]));
      step();
    end
    chk("idle_after", 0, 32'(busy[0]), 32'd0);
    drain();

    // Three words on consecutive cycles.
    push1(9'h055);
    p = t;
    push1(9'h0AA);
    chk("cnt_one", 0, 32'(cnt0), 32'd1);
    push1(9'h00F);
    chk("cnt_peak", 0, 32'(cnt0), 32'd2);
    while (t < p + 120) begin
      chk("b2b_busy", 0, 32'(busy[0]), 32'd1);
      step();
    end
    chk("b2b_busy_end", 0, 32'(busy[0]), 32'd1);
    step();
    chk("b2b_idle", 0, 32'(busy[0]), 32'd0);
    drain();

    // Hold valid for 20 cycles with an incrementing word.
    for (int i = 0; i < 20; i++) begin
      vld  = 1'b1;
      data = 9'(i + 1);
      step();
    end
    vld = 1'b0;
    chk("full_cnt", 0, 32'(cnt0), 32'd16);
    chk("full_rdy", 0, 32'(bus0.bus_rdy_o), 32'd0);
    drain();

    // Push coinciding with the pop at the last stop-bit cycle.
    push1(9'h011);
    p = t;
    push1(9'h022);
    while (t < p + 40) step();
    push1(9'h033);
    chk("simul_cnt", 0, 32'(cnt0), 32'd1);
    chk("simul_last_stop", 0, 32'(seri[0]), 32'd1);
    step();
    chk("simul_next_start", 0, 32'(seri[0]), 32'd0);
    drain();

    // Reset during DATA with four words queued.
    for (int i = 0; i < 5; i++) push1(9'(8'hC0 + i));
    p = t;
    chk("pre_rst_cnt", 0, 32'(cnt0), 32'd4);
    while (t < p + 4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NC; k++) begin
      chk("mid_rst_line", k, 32'(seri[k]), 32'd1);
      chk("mid_rst_busy", k, 32'(busy[k]), 32'd0);
      chk("mid_rst_cnt",  k, 32'(obs_cnt(k)), 32'd0);
      chk("mid_rst_rdy",  k, 32'(obs_rdy(k)), 32'd1);
    end
    repeat (120) step();

    // Random traffic with varying density and occasional resets.
    dens = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(3, 95);
      rst  = ($urandom_range(0, 799) == 0);
      vld  = !rst && ($urandom_range(0, 99) < dens);
      data = 9'($urandom);
      step();
    end
    rst = 1'b0;
    vld = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
